// File: rtl/timer_host_pkg.sv
// Shared constants for the interval-timer host: register map, control bits, FSM state codes.
package timer_host_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_SNAP_L  = 3'd4;
    localparam logic [2:0] REG_SNAP_H  = 3'd5;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    typedef logic [3:0] state_t;

    localparam state_t StInit   = 4'd0;
    localparam state_t StIdle   = 4'd1;
    localparam state_t StClr    = 4'd2;
    localparam state_t StCtrl   = 4'd3;
    localparam state_t StSnapWr = 4'd4;
    localparam state_t StSnapRl = 4'd5;
    localparam state_t StSnapWl = 4'd6;
    localparam state_t StSnapRh = 4'd7;
    localparam state_t StSnapWh = 4'd8;

    // Stop keeps the ITO/CONT bits of the init word, clears START, sets STOP.
    function automatic logic [15:0] stop_word(input logic [3:0] init);
        logic [15:0] w;
        w = 16'h0000;
        w[CTRL_ITO]  = init[CTRL_ITO];
        w[CTRL_CONT] = init[CTRL_CONT];
        w[CTRL_STOP] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/timer_host_rdpipe.sv
// Read-latency tracker: flags the cycle in which avm_readdata belongs to an accepted read.
module timer_host_rdpipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rd_accept_i,
    output logic capture_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = rd_accept_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign capture_o = valid_q[DEPTH-1];

endmodule

// File: rtl/timer_irq_host.sv
// Avalon-MM master driving the interval timer: init, IRQ clear, start/stop, tick counting.
// Define SNAPSHOT_EN to include the counter snapshot path (snap_req, snap_value, snap_valid).
module timer_irq_host
    import timer_host_pkg::*;
#(
    parameter logic [3:0]  CTRL_INIT    = 4'h7,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TICK_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              timer_irq,
    input  logic              start_req,
    input  logic              stop_req,
    input  logic              snap_req,
    output logic              busy,
    output logic              running,
    output logic [TICK_W-1:0] tick_count,
    output logic              tick_pulse,
    output logic [31:0]       snap_value,
    output logic              snap_valid
);

    state_t              state_q, state_d;
    logic [2:0]          addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                wn_q, wn_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                running_q, running_d;
    logic                busy_q;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                tick_pulse_q, tick_pulse_d;
    logic                settle_q, settle_d;
    logic                start_pend_q, start_pend_d;
    logic                stop_pend_q, stop_pend_d;
    logic                clr_start, clr_stop;
    logic                accept;
    logic                rd_capture;

    assign accept = cs_q & ~avm_waitrequest;

    timer_host_rdpipe #(
        .DEPTH (READ_LATENCY)
    ) u_rdpipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_accept_i (accept & wn_q),
        .capture_o   (rd_capture)
    );

`ifdef SNAPSHOT_EN
    logic        snap_pend_q, snap_pend_d;
    logic        clr_snap;
    logic [15:0] snap_lo_q, snap_lo_d;
    logic [31:0] snap_value_q, snap_value_d;
    logic        snap_valid_q, snap_valid_d;
`else
    logic unused_snap;
    assign unused_snap = ^{snap_req, avm_readdata, rd_capture};
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cs_d         = cs_q;
        wn_d         = wn_q;
        wdata_d      = wdata_q;
        running_d    = running_q;
        tick_d       = tick_q;
        tick_pulse_d = 1'b0;
        settle_d     = 1'b0;
        clr_start    = 1'b0;
        clr_stop     = 1'b0;
`ifdef SNAPSHOT_EN
        clr_snap     = 1'b0;
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
`endif

        case (state_q)
            StInit: begin
                if (!cs_q) begin
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = REG_CONTROL;
                    wdata_d = {12'h000, CTRL_INIT};
                end else if (accept) begin
                    cs_d      = 1'b0;
                    wn_d      = 1'b1;
                    running_d = CTRL_INIT[CTRL_START];
                    state_d   = StIdle;
                end
            end
            StIdle: begin
                // settle_q masks the IRQ level the slave is still dropping after a clear.
                if (timer_irq && !settle_q) begin
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = REG_STATUS;
                    wdata_d = 16'h0000;
                    state_d = StClr;
                end else if (stop_pend_q) begin
                    cs_d      = 1'b1;
                    wn_d      = 1'b0;
                    addr_d    = REG_CONTROL;
                    wdata_d   = stop_word(CTRL_INIT);
                    clr_stop  = 1'b1;
                    clr_start = 1'b1;
                    state_d   = StCtrl;
                end else if (start_pend_q) begin
                    cs_d      = 1'b1;
                    wn_d      = 1'b0;
                    addr_d    = REG_CONTROL;
                    wdata_d   = {12'h000, CTRL_INIT};
                    clr_start = 1'b1;
                    state_d   = StCtrl;
                end
`ifdef SNAPSHOT_EN
                else if (snap_pend_q) begin
                    cs_d     = 1'b1;
                    wn_d     = 1'b0;
                    addr_d   = REG_SNAP_L;
                    wdata_d  = 16'h0000;
                    clr_snap = 1'b1;
                    state_d  = StSnapWr;
                end
`endif
            end
            StClr: begin
                if (accept) begin
                    cs_d         = 1'b0;
                    wn_d         = 1'b1;
                    tick_d       = tick_q + TICK_W'(1);
                    tick_pulse_d = 1'b1;
                    settle_d     = 1'b1;
                    state_d      = StIdle;
                end
            end
            StCtrl: begin
                if (accept) begin
                    cs_d      = 1'b0;
                    wn_d      = 1'b1;
                    running_d = wdata_q[CTRL_START];
                    state_d   = StIdle;
                end
            end
`ifdef SNAPSHOT_EN
            StSnapWr: begin
                if (accept) begin
                    wn_d    = 1'b1;
                    addr_d  = REG_SNAP_L;
                    state_d = StSnapRl;
                end
            end
            StSnapRl: begin
                if (accept) begin
                    cs_d    = 1'b0;
                    state_d = StSnapWl;
                end
            end
            StSnapWl: begin
                if (rd_capture) begin
                    snap_lo_d = avm_readdata;
                    cs_d      = 1'b1;
                    wn_d      = 1'b1;
                    addr_d    = REG_SNAP_H;
                    state_d   = StSnapRh;
                end
            end
            StSnapRh: begin
                if (accept) begin
                    cs_d    = 1'b0;
                    state_d = StSnapWh;
                end
            end
            StSnapWh: begin
                if (rd_capture) begin
                    snap_value_d = {avm_readdata, snap_lo_q};
                    snap_valid_d = 1'b1;
                    state_d      = StIdle;
                end
            end
`endif
            default: begin
                cs_d    = 1'b0;
                wn_d    = 1'b1;
                state_d = StInit;
            end
        endcase

        // Pulses arriving in the servicing cycle stay pending for the next round.
        start_pend_d = (start_pend_q & ~clr_start) | start_req;
        stop_pend_d  = (stop_pend_q & ~clr_stop) | stop_req;
`ifdef SNAPSHOT_EN
        snap_pend_d  = (snap_pend_q & ~clr_snap) | snap_req;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StInit;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wdata_q      <= '0;
            running_q    <= 1'b0;
            busy_q       <= 1'b0;
            tick_q       <= '0;
            tick_pulse_q <= 1'b0;
            settle_q     <= 1'b0;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            wdata_q      <= wdata_d;
            running_q    <= running_d;
            busy_q       <= (state_d != StIdle);
            tick_q       <= tick_d;
            tick_pulse_q <= tick_pulse_d;
            settle_q     <= settle_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
        end
    end

`ifdef SNAPSHOT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_pend_q  <= 1'b0;
            snap_lo_q    <= '0;
            snap_value_q <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_pend_q  <= snap_pend_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign snap_value = snap_value_q;
    assign snap_valid = snap_valid_q;
`else
    assign snap_value = 32'h0000_0000;
    assign snap_valid = 1'b0;
`endif

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wdata_q;
    assign busy           = busy_q;
    assign running        = running_q;
    assign tick_count     = tick_q;
    assign tick_pulse     = tick_pulse_q;

endmodule
